cdb_rr_arbiter: RTL

Round-robin scheduler for the common data bus. Sits between the functional units and the single CDB broadcast register. Replaces fixed-priority single-slot holding with per-source FIFOs, a fair rotating grant, and per-source backpressure, so an FU can never overwrite a pending result and no FU starves.

---
 rtl/cdb_rr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cdb_rr_arbiter.sv
// Round-robin CDB scheduler: per-source result FIFOs, rotating grant, per-source backpressure.
// Optional macro CDB_BYPASS_EN: on an idle bus the winning input skips its FIFO (one-edge latency).

localparam int CDB_TAG_W = 4;
localparam int CDB_VAL_W = 32;
localparam logic [CDB_TAG_W-1:0] CDB_NO_VAL = '0;

typedef struct packed {
  logic [CDB_TAG_W-1:0] tag;
  logic [CDB_VAL_W-1:0] val;
} cdb_t;

module cdb_rr_arbiter #(
  parameter  int NUM_SRC = 5,
  parameter  int DEPTH   = 2,
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk_i,
  input  logic               RST_i,
  input  cdb_t               fu_res_i [NUM_SRC],
  output logic [NUM_SRC-1:0] fu_ready_o,
  output cdb_t               broadcast_o,
  output logic [SRC_W-1:0]   broadcast_src_o,
  output logic               overflow_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cdb_t             mem    [NUM_SRC][DEPTH];
  logic [PTR_W-1:0] rd_ptr [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr [NUM_SRC];
  logic [CNT_W-1:0] count  [NUM_SRC];
  logic [SRC_W-1:0] rr_ptr;

  logic [NUM_SRC-1:0] in_valid;
  logic [NUM_SRC-1:0] not_empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               grant_vld;
  logic [SRC_W-1:0]   grant_idx;
  logic               byp_vld;
  logic [SRC_W-1:0]   byp_idx;

  // First requester at or after start, wrapping; returns {found, index}.
  function automatic logic [SRC_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                             input logic [SRC_W-1:0]   start);
    logic [SRC_W:0]   res;
    logic [SRC_W-1:0] sel;
    int               idx;
    res = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      sel = SRC_W'(idx);
      if (req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] g);
    return (g == SRC_W'(NUM_SRC - 1)) ? '0 : g + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at the registered count, so a full FIFO that pops this cycle still refuses.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      in_valid[i]   = (fu_res_i[i].tag != CDB_NO_VAL);
      not_empty[i]  = (count[i] != '0);
      fu_ready_o[i] = (count[i] < CNT_W'(DEPTH)) && !RST_i;
    end
  end

  always_comb begin
    {grant_vld, grant_idx} = rr_pick(not_empty, rr_ptr);
  end

`ifdef CDB_BYPASS_EN
  always_comb begin
    {byp_vld, byp_idx} = rr_pick(in_valid & fu_ready_o, rr_ptr);
    if (grant_vld) byp_vld = 1'b0;
  end
`else
  assign byp_vld = 1'b0;
  assign byp_idx = '0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      push[i] = in_valid[i] && fu_ready_o[i] && !(byp_vld && (byp_idx == SRC_W'(i)));
      pop[i]  = grant_vld && (grant_idx == SRC_W'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (RST_i) begin
      rr_ptr          <= '0;
      broadcast_o.tag <= CDB_NO_VAL;
      broadcast_o.val <= '0;
      broadcast_src_o <= '0;
      overflow_o      <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= fu_res_i[i];
          wr_ptr[i]         <= next_ptr(wr_ptr[i]);
        end
        if (pop[i]) rd_ptr[i] <= next_ptr(rd_ptr[i]);
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
        if (in_valid[i] && !fu_ready_o[i]) overflow_o <= 1'b1;
      end

      if (grant_vld) begin
        broadcast_o     <= mem[grant_idx][rd_ptr[grant_idx]];
        broadcast_src_o <= grant_idx;
        rr_ptr          <= next_src(grant_idx);
      end else if (byp_vld) begin
        broadcast_o     <= fu_res_i[byp_idx];
        broadcast_src_o <= byp_idx;
        rr_ptr          <= next_src(byp_idx);
      end else begin
        broadcast_o.tag <= CDB_NO_VAL;
        broadcast_o.val <= '0;
        broadcast_src_o <= '0;
      end
    end
  end

endmodule
